// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised SPI master.
//   Configurable word width (DATA_W), SCLK half-period (clk_div+1 clk cycles),
//   all four CPOL/CPHA modes, MSB/LSB-first order and NUM_CS active-low selects.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   start/busy/done       controller handshake (start sampled only while idle)
//   tx_data, cs_sel,
//   cpol, cpha,
//   lsb_first, clk_div    transfer config, latched when start is accepted
//   rx_data               last received word, updated in the done cycle only
//   MOSI, MISO, SCLK, CS  SPI pins (all outputs registered)
module spi_master_cfg #(
  parameter int DATA_W   = 8,
  parameter int NUM_CS   = 1,
  parameter int DIV_W    = 8,
  localparam int CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb_first,
  input  logic [DIV_W-1:0]    clk_div,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic                done,
  output logic                MOSI,
  input  logic                MISO,
  output logic                SCLK,
  output logic [NUM_CS-1:0]   CS
);
  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic              cpha_q, cpha_d, lsb_q, lsb_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0] cs_q, cs_d;

  logic              tick, leading, last_edge, cur_bit, next_bit;
  logic [DATA_W-1:0] tx_shift, rx_shift;

  // Counter runs 0..clk_div, so H = clk_div+1 never needs a wider register.
  assign tick      = (cnt_q == div_q);
  // edge_q counts toggles already made; an even count means the next one leads.
  assign leading   = ~edge_q[0];
  assign last_edge = (edge_q == EW'(EDGES - 1));
  assign cur_bit   = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
  assign next_bit  = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
  assign tx_shift  = lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
  assign rx_shift  = lsb_q ? {MISO, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], MISO};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        cs_d   = '1;
        mosi_d = 1'b0;
        if (start) begin
          tx_d    = tx_data;
          div_d   = clk_div;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          cnt_d   = '0;
          edge_d  = '0;
          busy_d  = 1'b1;
          state_d = LEAD;
          // Out-of-range cs_sel matches no line: transfer runs unselected.
          for (int i = 0; i < NUM_CS; i++)
            if (cs_sel == CS_SEL_W'(i)) cs_d[i] = 1'b0;
          if (!cpha) mosi_d = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        end
      end
      LEAD: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      XFER: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          // Sample edge is leading for cpha=0, trailing for cpha=1.
          if (leading != cpha_q) rx_sh_d = rx_shift;
          if (cpha_q && leading) begin
            mosi_d = cur_bit;
            tx_d   = tx_shift;
          end
          if (!cpha_q && !leading && !last_edge) begin
            mosi_d = next_bit;
            tx_d   = tx_shift;
          end
          if (last_edge) state_d = TRAIL;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (tick) begin
          cnt_d   = '0;
          cs_d    = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign MOSI    = mosi_q;
  assign SCLK    = sclk_q;
  assign CS      = cs_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: an 8-bit/3-select instance and a 16-bit/4-select
// instance share config inputs; a negedge monitor watches the selected one,
// plays an SPI slave on MISO, and records what the slave sees on MOSI.
module tb_spi_master_cfg;
  logic clk = 1'b0;
  logic rst_n;
  logic start8, start16;
  logic [15:0] tx_data;
  logic [1:0]  cs_sel;
  logic cpol, cpha, lsb_first;
  logic [7:0]  clk_div;
  logic miso8, miso16;
  logic [7:0]  rx8;
  logic [15:0] rx16;
  logic busy8, done8, mosi8, sclk8, busy16, done16, mosi16, sclk16;
  logic [2:0]  cs8;
  logic [3:0]  cs16;

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .tx_data(tx_data[7:0]), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .rx_data(rx8), .busy(busy8), .done(done8), .MOSI(mosi8), .MISO(miso8),
    .SCLK(sclk8), .CS(cs8));

  spi_master_cfg #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .rx_data(rx16), .busy(busy16), .done(done16), .MOSI(mosi16), .MISO(miso16),
    .SCLK(sclk16), .CS(cs16));

  // Monitor / slave state
  bit sel16, loop, mon_cpha, mon_lsb, s_miso;
  int dw, mon_h, k;
  logic [15:0] s_word, mosi_seq;
  logic [3:0]  cs_low;
  int busy_len, edges, gap, gap_bad, done_cnt, done_base, cs_idle_bad;
  bit p_busy, p_sclk;
  int n_chk, n_err;

  logic m_sclk, m_mosi, m_busy, m_done;
  logic [3:0]  m_cs;
  logic [15:0] m_rx;
  assign m_sclk = sel16 ? sclk16 : sclk8;
  assign m_mosi = sel16 ? mosi16 : mosi8;
  assign m_busy = sel16 ? busy16 : busy8;
  assign m_done = sel16 ? done16 : done8;
  assign m_cs   = sel16 ? cs16 : {1'b1, cs8};
  assign m_rx   = sel16 ? rx16 : {8'h00, rx8};
  assign miso8  = loop ? mosi8 : s_miso;
  assign miso16 = loop ? mosi16 : s_miso;

  always @(negedge clk) begin
    if (m_busy && !p_busy) begin
      busy_len = 0; edges = 0; gap = 0; gap_bad = 0;
      mosi_seq = '0; cs_low = '0; p_sclk = m_sclk;
    end
    if (m_busy) begin
      busy_len++; gap++;
      cs_low = cs_low | ~m_cs;
      if (m_sclk != p_sclk) begin
        edges++;
        if (edges > 1 && gap != mon_h) gap_bad++;
        gap = 0;
        // slave samples MOSI on the edge where the master samples MISO
        if ((edges % 2 == 1) != mon_cpha) mosi_seq = {mosi_seq[14:0], m_mosi};
      end
    end else if (m_cs != 4'hF) cs_idle_bad++;
    if (m_done) done_cnt++;
    // bit index the slave presents: cpha=0 advances on trailing edges,
    // cpha=1 presents bit n right after leading edge n+1
    k = mon_cpha ? (edges + 1) / 2 - 1 : edges / 2;
    if (k < 0) k = 0;
    if (k > dw - 1) k = dw - 1;
    s_miso = mon_lsb ? s_word[k] : s_word[dw-1-k];
    p_busy = m_busy; p_sclk = m_sclk;
  end

  typedef struct {
    bit u16; logic [15:0] tx, sw; bit lp, cp, ch, lb;
    logic [7:0] dv; logic [1:0] cs;
    logic [15:0] erx, eseq; int ebusy; logic [3:0] ecs;
  } vec_t;

  function automatic vec_t mk(bit u16, logic [15:0] tx, sw, bit lp, cp, ch, lb,
                              logic [7:0] dv, logic [1:0] cs, logic [15:0] erx, eseq,
                              int ebusy, logic [3:0] ecs);
    vec_t v;
    v.u16 = u16; v.tx = tx; v.sw = sw; v.lp = lp; v.cp = cp; v.ch = ch; v.lb = lb;
    v.dv = dv; v.cs = cs; v.erx = erx; v.eseq = eseq; v.ebusy = ebusy; v.ecs = ecs;
    return v;
  endfunction

  // Order in which tx bits should appear on the wire, packed first-bit-highest.
  function automatic logic [15:0] wire_order(logic [15:0] w, int n, bit lsb);
    logic [15:0] s = '0;
    for (int j = 0; j < n; j++) s = {s[14:0], lsb ? w[j] : w[n-1-j]};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input vec_t v, input bit hold);
    @(negedge clk);
    sel16 = v.u16; loop = v.lp; s_word = v.sw; mon_cpha = v.ch; mon_lsb = v.lb;
    mon_h = int'(v.dv) + 1; dw = v.u16 ? 16 : 8;
    tx_data = v.tx; cpol = v.cp; cpha = v.ch; lsb_first = v.lb; clk_div = v.dv; cs_sel = v.cs;
    @(negedge clk);
    done_base = done_cnt;
    if (v.u16) start16 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    if (!hold) begin start8 = 1'b0; start16 = 1'b0; end
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    while (!m_done && i < 20000) begin @(negedge clk); #1; i++; end
    chk({nm, ".done_seen"}, 32'(m_done), 32'd1);
  endtask

  task automatic check_result(input vec_t v, input string nm);
    logic [15:0] mask;
    mask = v.u16 ? 16'hFFFF : 16'h00FF;
    chk({nm, ".rx"}, 32'(m_rx), 32'(v.erx & mask));
    chk({nm, ".busy_cycles"}, busy_len, v.ebusy);
    chk({nm, ".mosi_seq"}, 32'(mosi_seq & mask), 32'(v.eseq & mask));
    chk({nm, ".sclk_edges"}, edges, v.u16 ? 32 : 16);
    chk({nm, ".half_period_errs"}, gap_bad, 0);
    chk({nm, ".cs_active"}, 32'(cs_low), 32'(v.ecs));
    chk({nm, ".cs_in_done"}, 32'(m_cs), 32'hF);
    chk({nm, ".sclk_idle"}, 32'(m_sclk), 32'(v.cp));
    @(negedge clk); #1;
    chk({nm, ".done_width"}, 32'(m_done), 32'd0);
    chk({nm, ".done_count"}, done_cnt - done_base, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    launch(v, 1'b0);
    wait_done(nm);
    check_result(v, nm);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    rst_n = 1'b0; start8 = 0; start16 = 0; tx_data = '0; cs_sel = '0;
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = '0;
    sel16 = 0; loop = 0; dw = 8; mon_h = 1; s_word = '0;
    n_chk = 0; n_err = 0; done_cnt = 0; cs_idle_bad = 0;

    // columns: u16 tx sw lp cpol cpha lsb div cs | rx seq busy cs_mask
    tbl[0] = mk(0, 16'h00A5, 16'h003C, 0, 0, 0, 0, 8'd0, 2'd0, 16'h003C, 16'h00A5, 18, 4'b0001);
    tbl[1] = mk(0, 16'h0081, 16'h00F0, 0, 1, 1, 1, 8'd2, 2'd1, 16'h00F0, 16'h0081, 54, 4'b0010);
    tbl[2] = mk(1, 16'hBEEF, 16'h0000, 1, 0, 1, 0, 8'd1, 2'd2, 16'hBEEF, 16'hBEEF, 68, 4'b0100);
    tbl[3] = mk(1, 16'hBEEF, 16'h0000, 1, 1, 0, 0, 8'd0, 2'd2, 16'hBEEF, 16'hBEEF, 34, 4'b0100);
    tbl[4] = mk(0, 16'h0012, 16'h00C3, 0, 0, 1, 1, 8'd0, 2'd2, 16'h00C3, 16'h0048, 18, 4'b0100);
    tbl[5] = mk(0, 16'h005A, 16'h0096, 0, 1, 0, 0, 8'd3, 2'd0, 16'h0096, 16'h005A, 72, 4'b0001);
    tbl[6] = mk(0, 16'h0001, 16'h0080, 0, 0, 0, 0, 8'hFF, 2'd0, 16'h0080, 16'h0001, 4608, 4'b0001);
    // cs_sel=3 is out of range for the 3-select instance: no line asserts
    tbl[7] = mk(0, 16'h00C6, 16'h0039, 0, 1, 1, 0, 8'd0, 2'd3, 16'h0039, 16'h00C6, 18, 4'b0000);

    repeat (3) @(negedge clk);
    #1;
    chk("rst.cs8", 32'(cs8), 32'h7);
    chk("rst.cs16", 32'(cs16), 32'hF);
    chk("rst.sclk", 32'(sclk8 | sclk16), 32'd0);
    chk("rst.mosi", 32'(mosi8 | mosi16), 32'd0);
    chk("rst.busy", 32'(busy8 | busy16), 32'd0);
    chk("rst.done", 32'(done8 | done16), 32'd0);
    chk("rst.rx", 32'({rx16, rx8}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // start and config changes mid-transfer must not disturb it
    v = mk(0, 16'h006B, 16'h002D, 0, 0, 0, 0, 8'd1, 2'd0, 16'h002D, 16'h006B, 36, 4'b0001);
    launch(v, 1'b0);
    repeat (10) @(negedge clk);
    tx_data = 16'h00FF; cpol = 1; cpha = 1; clk_div = 8'd0; lsb_first = 1; cs_sel = 2'd1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done("ignore");
    check_result(v, "ignore");

    // back-to-back: start held through the done cycle
    v = mk(0, 16'h0011, 16'h00A7, 0, 0, 0, 0, 8'd0, 2'd0, 16'h00A7, 16'h0011, 18, 4'b0001);
    launch(v, 1'b1);
    wait_done("b2b1");
    chk("b2b1.rx", 32'(m_rx), 32'h00A7);
    chk("b2b1.mosi_seq", 32'(mosi_seq), 32'h0011);
    chk("b2b1.cs_high_gap", 32'(m_cs), 32'hF);
    tx_data = 16'h0022; s_word = 16'h005B;
    @(negedge clk); #1;
    chk("b2b2.restarted", 32'(m_busy), 32'd1);
    start8 = 1'b0;
    wait_done("b2b2");
    chk("b2b2.rx", 32'(m_rx), 32'h005B);
    chk("b2b2.mosi_seq", 32'(mosi_seq), 32'h0022);
    chk("b2b2.busy_cycles", busy_len, 18);
    chk("b2b.done_count", done_cnt - done_base, 2);

    // async reset in the middle of bit 4
    v = mk(0, 16'h0077, 16'h00E1, 0, 0, 0, 0, 8'd1, 2'd1, 16'h00E1, 16'h0077, 36, 4'b0010);
    launch(v, 1'b0);
    begin
      int i = 0;
      while (edges < 8 && i < 2000) begin @(negedge clk); #1; i++; end
    end
    chk("rst_mid.reached_bit4", 32'(edges >= 8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.cs", 32'(m_cs), 32'hF);
    chk("rst_mid.sclk", 32'(m_sclk), 32'd0);
    chk("rst_mid.busy", 32'(m_busy), 32'd0);
    chk("rst_mid.done", 32'(m_done), 32'd0);
    chk("rst_mid.rx", 32'(m_rx), 32'd0);
    done_base = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid.no_done", done_cnt - done_base, 0);
    run_vec(v, "after_rst");

    // randomized transfers against the wire-order model
    for (int i = 0; i < 24; i++) begin
      int w;
      v.u16 = 1'($urandom_range(0, 1));
      v.tx = 16'($urandom); v.sw = 16'($urandom);
      v.lp = 1'($urandom_range(0, 1)); v.cp = 1'($urandom_range(0, 1));
      v.ch = 1'($urandom_range(0, 1)); v.lb = 1'($urandom_range(0, 1));
      v.dv = 8'($urandom_range(0, 3)); v.cs = 2'($urandom_range(0, 3));
      w = v.u16 ? 16 : 8;
      v.erx = v.lp ? v.tx : v.sw;
      v.eseq = wire_order(v.tx, w, v.lb);
      v.ebusy = (2 * w + 2) * (int'(v.dv) + 1);
      v.ecs = (int'(v.cs) < (v.u16 ? 4 : 3)) ? 4'(1 << v.cs) : 4'h0;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    chk("cs_low_while_idle", cs_idle_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
